// File: rtl/enigma_pkg.sv
// Shared constants, stage record and elaboration helpers for the enigma_pipe cipher core.
package enigma_pkg;

  localparam int SYMB_W_MAX    = 16;
  localparam int ROTOR_NUM_MAX = 8;

  // Default rotor set for SYMB_W=7, ROTOR_NUM=3; rotor k sits at [k*7 +: 7].
  localparam logic [20:0] ROT_MUL_DEF = {7'd115, 7'd91, 7'd37};
  localparam logic [20:0] ROT_ADD_DEF = {7'd29, 7'd64, 7'd11};

  typedef enum logic {
    FWD,
    BWD
  } dir_e;

  // Sized for the largest legal configuration; unused upper bits stay zero.
  typedef struct packed {
    logic                                valid;
    logic [SYMB_W_MAX-1:0]               symbol;
    logic [ROTOR_NUM_MAX*SYMB_W_MAX-1:0] pos;
  } pipe_stage_t;

  // Inverse of an odd number mod 2^width; each Newton step doubles the correct low bits.
  function automatic logic [31:0] mod_inv(input logic [31:0] mul, input int width);
    logic [31:0] x;
    x = mul;
    for (int i = 0; i < 5; i++) begin
      x = x * (32'd2 - mul * x);
    end
    return x & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// One registered rotor mapping stage (forward map or its inverse) that holds on stall.
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter dir_e              DIR       = FWD,
  parameter int                SYMB_W    = 7,
  parameter int                ROTOR_IDX = 0,
  parameter logic [SYMB_W-1:0] MUL       = 1,
  parameter logic [SYMB_W-1:0] ADD       = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  pipe_stage_t stage_i,
  output pipe_stage_t stage_o
);

  logic [SYMB_W-1:0] x;
  logic [SYMB_W-1:0] p;
  logic [SYMB_W-1:0] y;
  pipe_stage_t       stage_d;
  logic              unused_sym;

  assign x          = stage_i.symbol[SYMB_W-1:0];
  assign p          = stage_i.pos[ROTOR_IDX*SYMB_W +: SYMB_W];
  assign unused_sym = ^stage_i.symbol;

  // All arithmetic wraps at SYMB_W bits, which is the mod-M reduction.
  if (DIR == FWD) begin : g_fwd
    assign y = MUL * (x + p) + ADD - p;
  end else begin : g_bwd
    localparam logic [SYMB_W-1:0] INV = SYMB_W'(mod_inv(32'(MUL), SYMB_W));
    assign y = INV * (x + p - ADD) - p;
  end

  always_comb begin
    // NOTE: the whole record is defaulted first so every path assigns it and no latch is inferred.
    stage_d                    = stage_i;
    stage_d.symbol             = '0;
    stage_d.symbol[SYMB_W-1:0] = y;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: data fields clear with valid; it costs little here and keeps symbol_o at 0 after reset.
      stage_o <= '0;
    end else if (!hold_i) begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      stage_o <= stage_d;
    end
  end

endmodule

// File: rtl/enigma_pipe.sv
// Fully pipelined Enigma-style cipher: forward rotors, reflector, inverse rotors, with
// valid/ready backpressure, runtime key loading and frame-based key reload.
module enigma_pipe
  import enigma_pkg::*;
#(
  parameter int                              SYMB_W    = 7,
  parameter int                              ROTOR_NUM = 3,
  parameter int                              CNT_W     = 8,
  parameter logic [ROTOR_NUM*SYMB_W-1:0]     ROT_MUL   = ROT_MUL_DEF,
  parameter logic [ROTOR_NUM*SYMB_W-1:0]     ROT_ADD   = ROT_ADD_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          key_load_i,
  input  logic [ROTOR_NUM*SYMB_W-1:0]   key_i,
  input  logic [CNT_W-1:0]              symb_numb_i,
  input  logic                          symb_val_i,
  output logic                          symb_rdy_o,
  input  logic [SYMB_W-1:0]             symbol_i,
  output logic                          symb_val_o,
  input  logic                          symb_rdy_i,
  output logic [SYMB_W-1:0]             symbol_o,
  output logic                          frame_done_o,
  output logic [ROTOR_NUM*SYMB_W-1:0]   rot_pos_o
);

  localparam int PW = ROTOR_NUM * SYMB_W;

  if (ROTOR_NUM < 1 || ROTOR_NUM > ROTOR_NUM_MAX) begin : g_bad_rotor_num
    $error("enigma_pipe: ROTOR_NUM must be 1..%0d", ROTOR_NUM_MAX);
  end
  if (SYMB_W < 1 || SYMB_W > SYMB_W_MAX) begin : g_bad_symb_w
    $error("enigma_pipe: SYMB_W must be 1..%0d", SYMB_W_MAX);
  end
  for (genvar k = 0; k < ROTOR_NUM; k++) begin : g_mul_chk
    if (ROT_MUL[k*SYMB_W] == 1'b0) begin : g_even
      $error("enigma_pipe: ROT_MUL for rotor %0d is even and has no inverse", k);
    end
  end

  pipe_stage_t      fwd [ROTOR_NUM+1];
  pipe_stage_t      bwd [ROTOR_NUM+1];
  pipe_stage_t      in_stage;
  pipe_stage_t      refl_d;
  pipe_stage_t      refl_q;
  logic [PW-1:0]    pos_q;
  logic [PW-1:0]    pos_step;
  logic [PW-1:0]    key_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             stall;
  logic             accept;
  logic             frame_hit;
  logic             frame_done_q;
  logic             unused_tail;

  assign stall      = bwd[ROTOR_NUM].valid & ~symb_rdy_i;
  assign symb_rdy_o = ~stall & ~key_load_i & ~rst_i;
  assign accept     = symb_val_i & symb_rdy_o;

  // The position snapshot taken before stepping travels with the symbol.
  always_comb begin
    in_stage                    = '0;
    in_stage.valid              = accept;
    in_stage.symbol[SYMB_W-1:0] = symbol_i;
    in_stage.pos[PW-1:0]        = pos_q;
  end

  assign fwd[0] = in_stage;

  for (genvar k = 0; k < ROTOR_NUM; k++) begin : g_fwd
    enigma_rotor_stage #(
      .DIR      (FWD),
      .SYMB_W   (SYMB_W),
      .ROTOR_IDX(k),
      .MUL      (ROT_MUL[k*SYMB_W +: SYMB_W]),
      .ADD      (ROT_ADD[k*SYMB_W +: SYMB_W])
    ) u_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hold_i (stall),
      .stage_i(fwd[k]),
      .stage_o(fwd[k+1])
    );
  end

  // Reflector: bitwise complement is an involution with no fixed point.
  always_comb begin
    refl_d                    = fwd[ROTOR_NUM];
    refl_d.symbol             = '0;
    refl_d.symbol[SYMB_W-1:0] = ~fwd[ROTOR_NUM].symbol[SYMB_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refl_q <= '0;
    end else if (!stall) begin
      refl_q <= refl_d;
    end
  end

  assign bwd[0] = refl_q;

  for (genvar j = 0; j < ROTOR_NUM; j++) begin : g_bwd
    localparam int K = ROTOR_NUM - 1 - j;
    enigma_rotor_stage #(
      .DIR      (BWD),
      .SYMB_W   (SYMB_W),
      .ROTOR_IDX(K),
      .MUL      (ROT_MUL[K*SYMB_W +: SYMB_W]),
      .ADD      (ROT_ADD[K*SYMB_W +: SYMB_W])
    ) u_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hold_i (stall),
      .stage_i(bwd[j]),
      .stage_o(bwd[j+1])
    );
  end

  // Odometer step: rotor k advances only when every lower rotor is about to wrap.
  always_comb begin
    logic carry;
    pos_step = pos_q;
    carry    = 1'b1;
    for (int k = 0; k < ROTOR_NUM; k++) begin
      pos_step[k*SYMB_W +: SYMB_W] = pos_q[k*SYMB_W +: SYMB_W] + SYMB_W'(carry);
      carry                        = carry & (&pos_q[k*SYMB_W +: SYMB_W]);
    end
  end

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign frame_hit = (symb_numb_i != '0) && (cnt_inc == symb_numb_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q        <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept & frame_hit;
      if (key_load_i) begin
        key_q <= key_i;
        pos_q <= key_i;
        cnt_q <= '0;
      end else if (accept) begin
        if (frame_hit) begin
          pos_q <= key_q;
          cnt_q <= '0;
        end else begin
          pos_q <= pos_step;
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign unused_tail  = ^{bwd[ROTOR_NUM].pos, bwd[ROTOR_NUM].symbol, fwd[ROTOR_NUM].symbol};
  assign symb_val_o   = bwd[ROTOR_NUM].valid;
  assign symbol_o     = bwd[ROTOR_NUM].symbol[SYMB_W-1:0];
  assign frame_done_o = frame_done_q;
  assign rot_pos_o    = pos_q;

endmodule

// File: tb/tb_enigma_pipe.sv
// Self-checking bench for enigma_pipe: directed sequence with random symbols, checked
// every cycle against an arithmetic reference model and a fixed-latency delay line.
module tb_enigma_pipe;

  localparam int SW   = 7;
  localparam int RN   = 3;
  localparam int CW   = 8;
  localparam int L    = 2 * RN + 1;
  localparam int M    = 1 << SW;
  localparam int PW   = RN * SW;
  localparam int MODV = M * M * M;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          key_load_i;
  logic [PW-1:0] key_i;
  logic [CW-1:0] symb_numb_i;
  logic          symb_val_i;
  logic [SW-1:0] symbol_i;
  logic          symb_rdy_i;
  logic          symb_rdy_o, symb_val_o, frame_done_o;
  logic [SW-1:0] symbol_o;
  logic [PW-1:0] rot_pos_o;
  logic          id_rdy_o, id_val_o, id_fd_o;
  logic [SW-1:0] id_symbol_o;
  logic [PW-1:0] id_pos_o;

  always #5 clk_i = ~clk_i;

  enigma_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_load_i(key_load_i), .key_i(key_i),
    .symb_numb_i(symb_numb_i), .symb_val_i(symb_val_i), .symb_rdy_o(symb_rdy_o),
    .symbol_i(symbol_i), .symb_val_o(symb_val_o), .symb_rdy_i(symb_rdy_i),
    .symbol_o(symbol_o), .frame_done_o(frame_done_o), .rot_pos_o(rot_pos_o)
  );

  enigma_pipe #(.ROT_MUL({RN{7'd1}}), .ROT_ADD('0)) dut_id (
    .clk_i(clk_i), .rst_i(rst_i), .key_load_i(key_load_i), .key_i(key_i),
    .symb_numb_i(symb_numb_i), .symb_val_i(symb_val_i), .symb_rdy_o(id_rdy_o),
    .symbol_i(symbol_i), .symb_val_o(id_val_o), .symb_rdy_i(symb_rdy_i),
    .symbol_o(id_symbol_o), .frame_done_o(id_fd_o), .rot_pos_o(id_pos_o)
  );

  // Reference rotor constants (rotor 0 first).
  int mul_k [RN] = '{37, 91, 115};
  int add_k [RN] = '{11, 64, 29};
  int inv_k [RN];

  int checks   = 0;
  int failures = 0;

  // Model state: positions as one base-M number, delay line of expected outputs.
  int pos_int, key_int, cnt;
  bit m_fd, m_acc;
  bit lv [L];
  int lx [L];
  int ly [L];
  int cap[$];
  int pt[$];
  int ct[$];
  int ref_a[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int md(input int a);
    return ((a % M) + M) % M;
  endfunction

  function automatic int enc(input int x, input int pos);
    int y, d;
    int p [RN];
    d = 1;
    for (int k = 0; k < RN; k++) begin
      p[k] = (pos / d) % M;
      d    = d * M;
    end
    y = x;
    for (int k = 0; k < RN; k++) y = md(mul_k[k] * ((y + p[k]) % M) + add_k[k] - p[k]);
    y = (M - 1) - y;
    for (int k = RN - 1; k >= 0; k--) y = md(inv_k[k] * (y + p[k] - add_k[k]) - p[k]);
    return y;
  endfunction

  function automatic bit busy();
    for (int k = 0; k < L; k++) if (lv[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    pos_int = 0; key_int = 0; cnt = 0; m_fd = 1'b0;
    for (int k = 0; k < L; k++) begin lv[k] = 1'b0; lx[k] = 0; ly[k] = 0; end
  endtask

  // One clock: check outputs at the falling edge, advance the model, return after the rising edge.
  task automatic cyc();
    bit m_stall, m_rdy;
    @(negedge clk_i);
    if (rst_i) model_reset();
    m_stall = lv[L-1] && !symb_rdy_i;
    m_rdy   = !m_stall && !key_load_i && !rst_i;
    check("symb_rdy_o", symb_rdy_o, m_rdy);
    check("symb_val_o", symb_val_o, lv[L-1]);
    if (lv[L-1]) begin
      check("symbol_o", symbol_o, ly[L-1]);
      check("out_ne_in", (int'(symbol_o) != lx[L-1]), 1);
    end else if (rst_i) begin
      check("symbol_o_rst", symbol_o, 0);
    end
    check("frame_done_o", frame_done_o, m_fd);
    check("rot_pos_o", rot_pos_o, 64'(pos_int));
    if (symb_val_o && symb_rdy_i) cap.push_back(int'(symbol_o));
    m_acc = symb_val_i && m_rdy;
    if (!m_stall && !rst_i) begin
      for (int k = L - 1; k > 0; k--) begin lv[k] = lv[k-1]; lx[k] = lx[k-1]; ly[k] = ly[k-1]; end
      lv[0] = m_acc; lx[0] = int'(symbol_i); ly[0] = enc(int'(symbol_i), pos_int);
    end
    m_fd = 1'b0;
    if (!rst_i) begin
      if (key_load_i) begin
        key_int = int'(key_i); pos_int = key_int; cnt = 0;
      end else if (m_acc) begin
        cnt = (cnt + 1) % (1 << CW);
        if (symb_numb_i != 0 && cnt == int'(symb_numb_i)) begin
          m_fd = 1'b1; cnt = 0; pos_int = key_int;
        end else begin
          pos_int = (pos_int + 1) % MODV;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input int s);
    int n = 0;
    symb_val_i = 1'b1;
    symbol_i   = SW'(s);
    do begin cyc(); n++; end while (!m_acc && n < 50);
    symb_val_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    symb_val_i = 1'b0;
    symb_rdy_i = 1'b1;
    while (busy() && n < 40) begin cyc(); n++; end
    cyc();
  endtask

  task automatic load_key(input logic [PW-1:0] k);
    key_load_i = 1'b1;
    key_i      = k;
    cyc();
    key_load_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c, idx, s;
    for (int k = 0; k < RN; k++)
      for (int v = 0; v < M; v++)
        if ((mul_k[k] * v) % M == 1) inv_k[k] = v;

    rst_i = 1'b1; key_load_i = 1'b0; key_i = '0; symb_numb_i = '0;
    symb_val_i = 1'b0; symbol_i = '0; symb_rdy_i = 1'b1;
    model_reset();
    cyc(); cyc();
    rst_i = 1'b0;
    cyc();

    // Identity rotors, key 0: 0x05 -> 0x7A after seven edges.
    send(5);
    repeat (5) cyc();
    check("id_val_early", id_val_o, 0);
    cyc();
    check("id_val", id_val_o, 1);
    check("id_symbol", id_symbol_o, 8'h7A);
    check("id_frame_done", id_fd_o, 0);
    drain();

    // Encrypt 100 random symbols, then decrypt with the same key.
    load_key({7'd3, 7'd17, 7'd90});
    cap.delete();
    for (int i = 0; i < 100; i++) begin
      s = int'($urandom_range(0, M - 1));
      pt.push_back(s);
      send(s);
      if ($urandom_range(0, 3) == 0) cyc();
    end
    drain();
    check("enc_count", cap.size(), 100);
    ct = cap;
    load_key({7'd3, 7'd17, 7'd90});
    cap.delete();
    foreach (ct[i]) send(ct[i]);
    drain();
    check("dec_count", cap.size(), 100);
    for (int i = 0; i < 100 && i < cap.size(); i++) check("dec_symbol", cap[i], pt[i]);

    // Odometer carry: 128 accepts wrap rotor 0 into rotor 1.
    load_key('0);
    for (int i = 0; i < 128; i++) send(int'($urandom_range(0, M - 1)));
    check("pos_after_128", rot_pos_o, {7'd0, 7'd1, 7'd0});
    send(int'($urandom_range(0, M - 1)));
    check("pos_after_129", rot_pos_o, {7'd0, 7'd1, 7'd1});
    drain();

    // Frame of 4 with key {0,0,5}: reload after the 4th accept.
    symb_numb_i = 8'd4;
    load_key({7'd0, 7'd0, 7'd5});
    cap.delete();
    for (int i = 0; i < 6; i++) begin
      send(8'h33);
      if (i == 3) begin
        check("frame_done_4th", frame_done_o, 1);
        check("pos_reload", rot_pos_o, 21'd5);
      end
    end
    drain();
    symb_numb_i = '0;
    check("frame_count", cap.size(), 6);
    if (cap.size() == 6) begin
      check("frame_repeat0", cap[4], cap[0]);
      check("frame_repeat1", cap[5], cap[1]);
    end

    // Backpressure: same key and symbols with and without stalls must match.
    pt.delete();
    for (int i = 0; i < 40; i++) pt.push_back(int'($urandom_range(0, M - 1)));
    load_key(21'h0ABCDE);
    cap.delete();
    foreach (pt[i]) send(pt[i]);
    drain();
    ref_a = cap;
    load_key(21'h0ABCDE);
    cap.delete();
    c = 0; idx = 0;
    while ((idx < 40 || busy()) && c < 400) begin
      symb_rdy_i = (c < 20) ? ((c % 2) == 0) : ((c < 40) ? 1'b0 : 1'b1);
      symb_val_i = (idx < 40);
      symbol_i   = SW'(pt[(idx < 40) ? idx : 39]);
      cyc();
      if (m_acc) idx++;
      c++;
    end
    drain();
    check("stall_count", cap.size(), ref_a.size());
    for (int i = 0; i < cap.size() && i < ref_a.size(); i++) check("stall_symbol", cap[i], ref_a[i]);

    // Reset with five symbols in flight.
    load_key({7'd9, 7'd8, 7'd7});
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, M - 1)));
    rst_i = 1'b1;
    cyc();
    check("rst_val", symb_val_o, 0);
    check("rst_pos", rot_pos_o, 0);
    rst_i = 1'b0;
    cap.delete();
    repeat (10) cyc();
    check("rst_no_emit", cap.size(), 0);
    send(8'h11);
    drain();
    check("rst_recover", cap.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
